// File: rtl/spram_bus_master_pkg.sv
// Shared types and defaults for the single-port RAM bus master.
package spram_bus_master_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int RD_LATENCY_DEF = 1;
  localparam int TURNAROUND_DEF = 1;

  // Wide enough for any practical read latency or turnaround length.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_TURN,
    ST_RESP,
    ST_VTURN
  } state_t;

endpackage

// File: rtl/spram_bus_master_rsp_buf.sv
// One-entry response register: captures a response on load and holds it
// until the client consumes it with rsp_ready.
module spram_bus_master_rsp_buf
  import spram_bus_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Load a new response, or drop valid once the client has taken it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_data;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spram_bus_master.sv
// Initiator for a single-port RAM with a shared bidirectional data bus.
// Optional feature macro: SPRAM_MASTER_WR_VERIFY_EN (read back every write
// and flag a mismatch on rsp_err).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a request, bus released
// ST_WRITE | one cycle driving addr/data with ce=1, we=1
// ST_READ  | RD_LATENCY cycles with ce=1, we=0, data sampled at the end
// ST_TURN  | TURNAROUND idle cycles, ce=0, bus released
// ST_RESP  | response held until rsp_ready
// ST_VTURN | one idle cycle between a write and its readback (verify only)
module spram_bus_master
  import spram_bus_master_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int TURNAROUND = TURNAROUND_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_ce,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TURNAROUND - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_load;
  logic              rsp_err_in;

`ifdef SPRAM_MASTER_WR_VERIFY_EN
  logic verify_q;
  logic err_q;
  assign rsp_err_in = err_q;
`else
  assign rsp_err_in = 1'b0;
`endif

  // The master only drives the bus during its own write cycle.
  assign mem_data = (mem_ce && mem_we) ? wdata_q : {DATA_W{1'bz}};

  assign req_ready = (state == ST_IDLE) && !rsp_valid && !rst;

  // The response lands in the buffer on the edge that ends the last TURN cycle.
  assign rsp_load = (state == ST_TURN) && (cnt == '0);

  // Transaction sequencer; bus pins are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_ce   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef SPRAM_MASTER_WR_VERIFY_EN
      verify_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            mem_addr <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            mem_ce   <= 1'b1;
            mem_we   <= req_we;
`ifdef SPRAM_MASTER_WR_VERIFY_EN
            verify_q <= 1'b0;
            err_q    <= 1'b0;
`endif
            if (req_we) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
              cnt   <= RD_LOAD;
            end
          end
        end
        ST_WRITE: begin
          mem_ce <= 1'b0;
          mem_we <= 1'b0;
`ifdef SPRAM_MASTER_WR_VERIFY_EN
          state  <= ST_VTURN;
`else
          state  <= ST_TURN;
          cnt    <= TA_LOAD;
`endif
        end
`ifdef SPRAM_MASTER_WR_VERIFY_EN
        ST_VTURN: begin
          mem_ce   <= 1'b1;
          verify_q <= 1'b1;
          state    <= ST_READ;
          cnt      <= RD_LOAD;
        end
`endif
        ST_READ: begin
          if (cnt == '0) begin
            rdata_q <= mem_data;
`ifdef SPRAM_MASTER_WR_VERIFY_EN
            err_q   <= verify_q && (mem_data != wdata_q);
`endif
            mem_ce  <= 1'b0;
            state   <= ST_TURN;
            cnt     <= TA_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_TURN: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spram_bus_master_rsp_buf #(
    .DATA_W(DATA_W)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (rsp_load),
    .load_data (rdata_q),
    .load_err  (rsp_err_in),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

endmodule
